// File: rtl/synth_pkg.sv
// Shared constants and types for the synthesiser voice control block.
package synth_pkg;

    localparam int unsigned FCW_W     = 20;
    localparam int unsigned ENV_W     = 16;
    localparam int unsigned CMD_W     = 16;
    localparam int unsigned OP_W      = 4;
    localparam int unsigned PAYLOAD_W = 12;
    localparam int unsigned RATE_W    = 12;
    localparam int unsigned FCW_LO_W  = 12;
    localparam int unsigned FCW_HI_W  = 8;
    localparam int unsigned WAVE_W    = 2;

    localparam logic [ENV_W-1:0] ENV_MAX = 16'hFFFF;

    localparam logic [OP_W-1:0] OP_FCW_LO   = 4'h1;
    localparam logic [OP_W-1:0] OP_FCW_HI   = 4'h2;
    localparam logic [OP_W-1:0] OP_WAVE     = 4'h3;
    localparam logic [OP_W-1:0] OP_ATTACK   = 4'h4;
    localparam logic [OP_W-1:0] OP_DECAY    = 4'h5;
    localparam logic [OP_W-1:0] OP_SUSTAIN  = 4'h6;
    localparam logic [OP_W-1:0] OP_RELEASE  = 4'h7;
    localparam logic [OP_W-1:0] OP_GATE_ON  = 4'h8;
    localparam logic [OP_W-1:0] OP_GATE_OFF = 4'h9;

    typedef struct packed {
        logic [OP_W-1:0]      op;
        logic [PAYLOAD_W-1:0] payload;
    } cmd_t;

    typedef enum logic [2:0] {
        ENV_IDLE,
        ENV_ATTACK,
        ENV_DECAY,
        ENV_SUSTAIN,
        ENV_RELEASE
    } env_state_e;

    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return (op >= OP_FCW_LO) && (op <= OP_GATE_OFF);
    endfunction

endpackage

// File: rtl/env_gen.sv
// ADSR envelope generator; advances on the sample tick, applying any pending
// gate event before that tick's arithmetic.
module env_gen
    import synth_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              gate_evt,
    input  logic              gate_on,
    input  logic [RATE_W-1:0] att_rate,
    input  logic [RATE_W-1:0] dec_rate,
    input  logic [RATE_W-1:0] rel_rate,
    input  logic [ENV_W-1:0]  sustain,
    output logic [ENV_W-1:0]  env,
    output logic              busy
);

    localparam int unsigned SUM_W = ENV_W + 1;

    env_state_e       state_q, state_d, gated_state;
    logic [ENV_W-1:0] env_q, env_d;
    logic             busy_q;
    logic [SUM_W-1:0] att_sum, dec_diff;
    logic [ENV_W-1:0] rel_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ENV_IDLE;
            env_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            env_q   <= env_d;
            busy_q  <= (state_d != ENV_IDLE);
        end
    end

    always_comb begin
        state_d     = state_q;
        env_d       = env_q;
        gated_state = state_q;
        rel_ext     = ENV_W'(rel_rate);
        att_sum     = {1'b0, env_q} + SUM_W'(att_rate);
        dec_diff    = {1'b0, env_q} - SUM_W'(dec_rate);

        // Gate on retriggers from the current level; gate off only leaves an active phase
        if (gate_evt) begin
            if (gate_on) begin
                gated_state = ENV_ATTACK;
            end else if (state_q == ENV_ATTACK || state_q == ENV_DECAY ||
                         state_q == ENV_SUSTAIN) begin
                gated_state = ENV_RELEASE;
            end
        end

        if (tick) begin
            state_d = gated_state;
            case (gated_state)
                ENV_ATTACK: begin
                    if (att_rate != '0) begin
                        if (att_sum >= {1'b0, ENV_MAX}) begin
                            env_d   = ENV_MAX;
                            state_d = ENV_DECAY;
                        end else begin
                            env_d = att_sum[ENV_W-1:0];
                        end
                    end
                end
                ENV_DECAY: begin
                    if (dec_rate != '0) begin
                        if (dec_diff[ENV_W] || (dec_diff[ENV_W-1:0] <= sustain)) begin
                            env_d   = sustain;
                            state_d = ENV_SUSTAIN;
                        end else begin
                            env_d = dec_diff[ENV_W-1:0];
                        end
                    end
                end
                ENV_SUSTAIN: env_d = sustain;
                ENV_RELEASE: begin
                    if (rel_rate != '0) begin
                        if (env_q <= rel_ext) begin
                            env_d   = '0;
                            state_d = ENV_IDLE;
                        end else begin
                            env_d = env_q - rel_ext;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign env  = env_q;
    assign busy = busy_q;

endmodule

// File: rtl/synth_ctrl.sv
// Voice control block: command decode, configuration registers, tick-aligned
// FCW commit and the envelope generator instance.
module synth_ctrl
    import synth_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_tick,
    input  logic              i_cmd_valid,
    input  logic [CMD_W-1:0]  i_cmd,
    output logic              o_cmd_ready,
    output logic [FCW_W-1:0]  o_fcw,
    output logic [WAVE_W-1:0] o_wave_sel,
    output logic [ENV_W-1:0]  o_env,
    output logic              o_env_busy,
    output logic              o_err
);

    cmd_t              cmd;
    logic              accept;
    logic              cmd_ready_q;
    logic [FCW_W-1:0]  fcw_q, staged_q;
    logic [WAVE_W-1:0] wave_q;
    logic [RATE_W-1:0] att_q, dec_q, rel_q;
    logic [ENV_W-1:0]  sustain_q;
    logic              gate_pend_q, gate_on_q;
    logic              err_q;

    assign cmd    = cmd_t'(i_cmd);
    assign accept = i_cmd_valid && cmd_ready_q;

    // Ready doubles as "no commit pending": it drops on the high-FCW write and
    // returns on the committing tick, so staging cannot change under a pending commit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cmd_ready_q <= 1'b1;
            fcw_q       <= '0;
            staged_q    <= '0;
            wave_q      <= '0;
            att_q       <= RATE_W'(1);
            dec_q       <= RATE_W'(1);
            rel_q       <= RATE_W'(1);
            sustain_q   <= 16'h8000;
            gate_pend_q <= 1'b0;
            gate_on_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= accept && !op_legal(cmd.op);

            if (i_tick && !cmd_ready_q) begin
                fcw_q       <= staged_q;
                cmd_ready_q <= 1'b1;
            end

            if (i_tick) begin
                gate_pend_q <= 1'b0;
            end

            if (accept) begin
                case (cmd.op)
                    OP_FCW_LO: staged_q[FCW_LO_W-1:0] <= cmd.payload;
                    OP_FCW_HI: begin
                        staged_q[FCW_W-1:FCW_LO_W] <= cmd.payload[FCW_HI_W-1:0];
                        cmd_ready_q                <= 1'b0;
                    end
                    OP_WAVE:     wave_q    <= cmd.payload[WAVE_W-1:0];
                    OP_ATTACK:   att_q     <= cmd.payload;
                    OP_DECAY:    dec_q     <= cmd.payload;
                    OP_SUSTAIN:  sustain_q <= {cmd.payload, 4'h0};
                    OP_RELEASE:  rel_q     <= cmd.payload;
                    OP_GATE_ON: begin
                        gate_pend_q <= 1'b1;
                        gate_on_q   <= 1'b1;
                    end
                    OP_GATE_OFF: begin
                        gate_pend_q <= 1'b1;
                        gate_on_q   <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    env_gen u_env_gen (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .tick     (i_tick),
        .gate_evt (gate_pend_q),
        .gate_on  (gate_on_q),
        .att_rate (att_q),
        .dec_rate (dec_q),
        .rel_rate (rel_q),
        .sustain  (sustain_q),
        .env      (o_env),
        .busy     (o_env_busy)
    );

    assign o_cmd_ready = cmd_ready_q;
    assign o_fcw       = fcw_q;
    assign o_wave_sel  = wave_q;
    assign o_err       = err_q;

endmodule
